// File: rtl/dotgen_if.sv
// Pixel-stage bus for dotgen: fetch-stage inputs, font ROM port and DAC-side outputs.
// master = upstream fetch + font ROM side, slave = dotgen.
interface dotgen_if;
    logic        hsync_in;
    logic        vsync_in;
    logic        de_in;
    logic [2:0]  hctr_in;
    logic [2:0]  vctr_in;
    logic [7:0]  character_in;
    logic [7:0]  color_in;
    logic [10:0] font_addr;
    logic        font_ena;
    logic [7:0]  font_rdata;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;
    logic [11:0] rgb_out;

    modport master (
        output hsync_in, vsync_in, de_in, hctr_in, vctr_in, character_in, color_in,
        output font_rdata,
        input  font_addr, font_ena,
        input  hsync_out, vsync_out, de_out, rgb_out
    );

    modport slave (
        input  hsync_in, vsync_in, de_in, hctr_in, vctr_in, character_in, color_in,
        input  font_rdata,
        output font_addr, font_ena,
        output hsync_out, vsync_out, de_out, rgb_out
    );
endinterface

// File: rtl/dotgen.sv
// Text-mode dot generator: font ROM lookup, dot select, CGA palette, 2-cycle aligned outputs.
// Optional attribute blink is built when DOTGEN_BLINK_EN is defined.
module dotgen #(
    parameter int BLINK_FRAMES = 16,
    parameter bit VSYNC_ACTIVE = 1'b1
) (
    input logic     CLK_108MHz,
    input logic     reset,
    dotgen_if.slave bus
);

    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255 || $bits(VSYNC_ACTIVE) != 1) begin : g_bad_param
        $error("dotgen: BLINK_FRAMES must be 1..255");
    end

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       de;
        logic [2:0] hctr;
        logic [7:0] color;
    } s1_t;

    s1_t         s1;
    logic        hsync_q, vsync_q, de_q;
    logic [11:0] rgb_q;

    // Brown (index 6) is the one entry that breaks the I/R/G/B channel rule.
    function automatic logic [11:0] palette(input logic [3:0] idx);
        logic [3:0] on, off;
        on  = idx[3] ? 4'hF : 4'hA;
        off = idx[3] ? 4'h5 : 4'h0;
        if (idx == 4'd6) return 12'hA50;
        return {idx[2] ? on : off, idx[1] ? on : off, idx[0] ? on : off};
    endfunction

    assign bus.font_addr = {bus.character_in, bus.vctr_in};
    assign bus.font_ena  = bus.de_in;

    always_ff @(posedge CLK_108MHz or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
        end else begin
            s1 <= '{hsync: bus.hsync_in, vsync: bus.vsync_in, de: bus.de_in,
                    hctr: bus.hctr_in, color: bus.color_in};
        end
    end

`ifdef DOTGEN_BLINK_EN
    logic       vs_prev;
    logic       vs_edge;
    logic [7:0] frame_cnt;
    logic       blink_phase;

    assign vs_edge = (bus.vsync_in == VSYNC_ACTIVE) && (vs_prev != VSYNC_ACTIVE);

    always_ff @(posedge CLK_108MHz or negedge reset) begin
        if (!reset) begin
            vs_prev     <= 1'b0;
            frame_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else begin
            vs_prev <= bus.vsync_in;
            if (vs_edge) begin
                if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= 8'd0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end
`endif

    logic       dot;
    logic [3:0] fg, bg, idx;
    logic [11:0] pix;

    always_comb begin
        dot = bus.font_rdata[3'd7 - s1.hctr];
        fg  = s1.color[3:0];
`ifdef DOTGEN_BLINK_EN
        bg  = {1'b0, s1.color[6:4]};
        // Blinking cells show background for the whole "off" half-period.
        idx = (dot && !(s1.color[7] && blink_phase)) ? fg : bg;
`else
        bg  = s1.color[7:4];
        idx = dot ? fg : bg;
`endif
        pix = s1.de ? palette(idx) : 12'h000;
    end

    always_ff @(posedge CLK_108MHz or negedge reset) begin
        if (!reset) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
            rgb_q   <= 12'h000;
        end else begin
            hsync_q <= s1.hsync;
            vsync_q <= s1.vsync;
            de_q    <= s1.de;
            rgb_q   <= pix;
        end
    end

    assign bus.hsync_out = hsync_q;
    assign bus.vsync_out = vsync_q;
    assign bus.de_out    = de_q;
    assign bus.rgb_out   = rgb_q;

endmodule

// File: tb/tb_dotgen.sv
// Bench for dotgen: directed vector table, blink sequence (DOTGEN_BLINK_EN), random vs. reference model.
module tb_dotgen;

    localparam int BF = 2;
    localparam logic [11:0] PAL [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

    typedef struct {
        logic        de, hs, vs;
        logic [2:0]  h, v;
        logic [7:0]  ch, col, glyph;
        logic        use_model;
        logic [11:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dotgen_if bus ();
    dotgen #(.BLINK_FRAMES(BF), .VSYNC_ACTIVE(1'b1)) dut (
        .CLK_108MHz(clk), .reset(rst_n), .bus(bus));

    int   total = 0;
    int   bad = 0;
    vec_t hist[$];
    logic [7:0] rom [2048];
    int   m_cnt;
    logic m_phase, m_vsp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t zero_rec();
        vec_t r;
        r = '{de: 1'b0, hs: 1'b0, vs: 1'b0, h: 3'd0, v: 3'd0, ch: 8'd0, col: 8'd0,
              glyph: 8'd0, use_model: 1'b0, exp: 12'h000};
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_phase = 1'b0; m_vsp = 1'b0;
        hist.delete();
        hist.push_back(zero_rec());
    endtask

    // Blink bookkeeping: count rising vsync levels; toggle phase every BF edges.
    task automatic model_vs(input logic vs);
        if (vs && !m_vsp) begin
            if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = !m_phase; end
            else m_cnt++;
        end
        m_vsp = vs;
    endtask

    function automatic logic [11:0] model_rgb(input vec_t r);
        logic       d;
        logic [3:0] i;
        if (!r.de) return 12'h000;
        d = r.glyph[7 - int'(r.h)];
`ifdef DOTGEN_BLINK_EN
        if (r.col[7] && m_phase) i = {1'b0, r.col[6:4]};
        else i = d ? r.col[3:0] : {1'b0, r.col[6:4]};
`else
        i = d ? r.col[3:0] : r.col[7:4];
`endif
        return PAL[i];
    endfunction

    // One pixel clock: apply r, check the ROM port, then check the pixel issued two cycles earlier.
    task automatic step(input vec_t r_in);
        vec_t r, p;
        r = r_in;
        model_vs(r.vs);
        if (r.use_model) r.exp = model_rgb(r);
        bus.hsync_in = r.hs; bus.vsync_in = r.vs; bus.de_in = r.de;
        bus.hctr_in = r.h; bus.vctr_in = r.v; bus.character_in = r.ch; bus.color_in = r.col;
        bus.font_rdata = hist[$].glyph;
        hist.push_back(r);
        #1;
        chk("font_addr", 32'(bus.font_addr), 32'({r.ch, r.v}));
        chk("font_ena", 32'(bus.font_ena), 32'(r.de));
        @(posedge clk); #1;
        p = hist[$-1];
        chk("sync_de", 32'({bus.hsync_out, bus.vsync_out, bus.de_out}), 32'({p.hs, p.vs, p.de}));
        chk("rgb", 32'(bus.rgb_out), 32'(p.exp));
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    function automatic vec_t rand_rec(input logic prev_vs);
        vec_t r;
        r = zero_rec();
        r.de  = ($urandom_range(0, 7) != 0);
        r.hs  = 1'($urandom_range(0, 1));
        r.vs  = ($urandom_range(0, 7) == 0) ? !prev_vs : prev_vs;
        r.h   = 3'($urandom); r.v = 3'($urandom);
        r.ch  = 8'($urandom); r.col = 8'($urandom);
        r.glyph = rom[{r.ch, r.v}];
        r.use_model = 1'b1;
        return r;
    endfunction

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) step(rand_rec(bus.vsync_in));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

`ifdef DOTGEN_BLINK_EN
    task automatic bl(input logic vs, input logic [11:0] e, input int n);
        vec_t r;
        for (int i = 0; i < n; i++) begin
            r = zero_rec();
            r.de = 1'b1; r.vs = vs; r.col = 8'h9F; r.glyph = 8'h80; r.exp = e;
            step(r);
        end
    endtask
`endif

    vec_t tbl[20];

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);

        // Directed vectors: constant expectations from the palette table.
        tbl[0] = zero_rec(); tbl[0].de = 1; tbl[0].ch = 8'h41; tbl[0].v = 3; tbl[0].col = 8'h1E;
        tbl[0].glyph = 8'h80; tbl[0].h = 0; tbl[0].exp = 12'hFF5;
        tbl[1] = tbl[0]; tbl[1].h = 1; tbl[1].exp = 12'h00A;
        tbl[2] = zero_rec(); tbl[2].hs = 1; tbl[2].vs = 1; tbl[2].glyph = 8'hFF; tbl[2].col = 8'h1E;
        tbl[3] = tbl[2]; tbl[3].hs = 0;
        for (int i = 0; i < 16; i++) begin
            tbl[4 + i] = zero_rec();
            tbl[4 + i].de = 1; tbl[4 + i].h = 3'(i); tbl[4 + i].col = 8'(i);
            tbl[4 + i].glyph = 8'hFF; tbl[4 + i].exp = PAL[i];
        end

        // Reset held with random inputs: outputs stay quiet.
        bus.font_rdata = 8'd0;
        for (int i = 0; i < 4; i++) begin
            bus.hsync_in = 1'($urandom); bus.vsync_in = 1'($urandom); bus.de_in = 1'($urandom);
            bus.hctr_in = 3'($urandom); bus.vctr_in = 3'($urandom);
            bus.character_in = 8'($urandom); bus.color_in = 8'($urandom);
            bus.font_rdata = 8'($urandom);
            @(posedge clk); #1;
            chk("reset_out", 32'({bus.hsync_out, bus.vsync_out, bus.de_out, bus.rgb_out}), 32'd0);
        end
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 20; i++) step(tbl[i]);
        begin
            vec_t r;
            r = zero_rec(); r.de = 1; r.col = 8'h9F; r.glyph = 8'h00;
`ifdef DOTGEN_BLINK_EN
            r.exp = 12'h00A;
`else
            r.exp = 12'h55F;
`endif
            step(r);
        end
        step(zero_rec());
        step(zero_rec());

`ifdef DOTGEN_BLINK_EN
        do_reset();
        bl(0, 12'hFFF, 3);
        bl(1, 12'hFFF, 5);
        bl(0, 12'hFFF, 2);
        bl(1, 12'h00A, 3);
        bl(0, 12'h00A, 2);
        bl(1, 12'h00A, 2);
        bl(0, 12'h00A, 1);
        bl(1, 12'hFFF, 2);
        bl(0, 12'hFFF, 2);
`endif

        run_random(300);

        // Reset mid-line: outputs drop without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 32'({bus.hsync_out, bus.vsync_out, bus.de_out, bus.rgb_out}), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold", 32'({bus.hsync_out, bus.vsync_out, bus.de_out, bus.rgb_out}), 32'd0);
        rst_n = 1'b1;
        model_reset();
        run_random(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
